// File: rtl/pcm_serial_tx.sv
// pcm_serial_tx -- transmit end of the noise-cancellation datapath.
// Buffers filtered samples in a small FIFO and shifts each one out MSB-first
// on a 3-wire DAC link (sclk / fsync / sdata), with a one-bit idle gap
// between frames.
//
// Optional feature macro: TX_PARITY_EN -- when defined, an even-parity bit
// (XOR of all data bits) is appended after the LSB, so frames are DATA_W+1
// bits long.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   sample present on in_data
//   in_data    in   [DATA_W-1:0] sample (sent as raw bits)
//   in_ready   out  FIFO not full (combinational)
//   sclk       out  serial bit clock, low when idle; DAC samples on rising edge
//   fsync      out  high for the whole MSB bit period of each frame
//   sdata      out  serial data, MSB first; 0 when idle
//   busy       out  high in LOAD, SHIFT or GAP
//   overflow   out  sticky: a sample was offered while full
//   fifo_level out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
module pcm_serial_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          sclk,
  output logic                          fsync,
  output logic                          sdata,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_W);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [1:0]        state;
  logic              push, pop;

  assign in_ready   = (level != FULL_LVL);
  assign fifo_level = level;
  // in_ready already excludes full, so a same-edge pop never lets a push in.
  assign push = in_valid & in_ready;
  assign pop  = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- serializer
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] frame_word;
  logic [DIV_W-1:0]   div;
  logic [BIT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  head;

  assign head = mem[rd_ptr];
`ifdef TX_PARITY_EN
  assign frame_word = {head, ^head};
`else
  assign frame_word = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (level != '0) state <= S_LOAD;
        end
        S_LOAD: begin
          shift_reg <= frame_word;
          bit_idx   <= '0;
          div       <= '0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div == DIV_LAST) begin
            // Bit boundary: next bit appears on sdata as div wraps to 0.
            div       <= '0;
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= S_GAP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_GAP: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            state <= (level != '0) ? S_LOAD : S_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so idle/gap levels need no extra regs.
  assign busy  = (state != S_IDLE);
  assign sdata = (state == S_SHIFT) & shift_reg[FRAME_W-1];
  assign fsync = (state == S_SHIFT) && (bit_idx == '0);
  assign sclk  = (state == S_SHIFT) && (div >= DIV_HALF);

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Directed bench for pcm_serial_tx (DATA_W=16, FIFO_DEPTH=8, CLK_DIV=4).
// Define TX_PARITY_EN for both files to exercise the parity frame.
module tb_pcm_serial_tx;

`ifdef TX_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, sclk, fsync, sdata, busy, overflow;
  logic [3:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;

  pcm_serial_tx #(.DATA_W(16), .FIFO_DEPTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sclk(sclk), .fsync(fsync), .sdata(sdata),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Advance one edge; sampling and driving happen 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first SHIFT cycle of a frame; checks every bit cycle and
  // the 4-cycle gap, then returns just after the edge ending the gap.
  task automatic check_frame(input logic [15:0] d, input logic par);
    for (int c = 0; c < FW * 4; c++) begin
      int  b;
      logic eb;
      b  = c / 4;
      eb = (b < 16) ? d[15 - b] : par;
      chk($sformatf("sdata[%0h c%0d]", d, c), {31'd0, sdata}, {31'd0, eb});
      chk($sformatf("sclk[c%0d]", c), {31'd0, sclk}, {31'd0, (c % 4) >= 2});
      chk($sformatf("fsync[c%0d]", c), {31'd0, fsync}, {31'd0, c < 4});
      chk("busy_shift", {31'd0, busy}, 32'd1);
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      chk("gap_sdata", {31'd0, sdata}, 32'd0);
      chk("gap_sclk", {31'd0, sclk}, 32'd0);
      chk("gap_fsync", {31'd0, fsync}, 32'd0);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    logic seen;

    // 1. reset
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_fsync", {31'd0, fsync}, 32'd0);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // 2. single frame A5C3
    in_valid = 1'b1; in_data = 16'hA5C3;
    tick();                                   // E
    in_valid = 1'b0;
    chk("t2_level_E", {28'd0, fifo_level}, 32'd1);
    chk("t2_busy_E", {31'd0, busy}, 32'd0);
    tick();                                   // E+1: LOAD
    chk("t2_busy_load", {31'd0, busy}, 32'd1);
    chk("t2_fsync_load", {31'd0, fsync}, 32'd0);
    tick();                                   // E+2: MSB out
    chk("t2_level_E2", {28'd0, fifo_level}, 32'd0);
    check_frame(16'hA5C3, 1'b0);
    chk("t2_busy_fall", {31'd0, busy}, 32'd0);

    // 3. three back-to-back frames
    in_valid = 1'b1; in_data = 16'h8001; tick();
    in_data = 16'h7FFE; tick();
    in_data = 16'h0000; tick();
    in_valid = 1'b0;
    chk("t3_level", {28'd0, fifo_level}, 32'd2);
    check_frame(16'h8001, 1'b0);
    chk("t3_load1_busy", {31'd0, busy}, 32'd1);
    chk("t3_load1_fsync", {31'd0, fsync}, 32'd0);
    tick();
    check_frame(16'h7FFE, 1'b0);
    chk("t3_load2_busy", {31'd0, busy}, 32'd1);
    chk("t3_load2_fsync", {31'd0, fsync}, 32'd0);
    tick();
    check_frame(16'h0000, 1'b0);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);
    chk("t3_idle_level", {28'd0, fifo_level}, 32'd0);

`ifdef TX_PARITY_EN
    // 6. parity bit
    in_valid = 1'b1; in_data = 16'h0001; tick();
    in_data = 16'h0003; tick();
    in_valid = 1'b0;
    tick();
    check_frame(16'h0001, 1'b1);
    chk("t6_load_busy", {31'd0, busy}, 32'd1);
    tick();
    check_frame(16'h0003, 1'b0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
`endif

    // 4. overflow: 10 cycles of in_valid from empty
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'h1000 + 16'(i);
      tick();
    end
    chk("t4_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t4_level_full", {28'd0, fifo_level}, 32'd8);
    chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
    tick();                                   // 10th cycle refused
    in_valid = 1'b0;
    chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
    chk("t4_level_hold", {28'd0, fifo_level}, 32'd8);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5. reset mid-frame with 3 queued
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
    chk("t5_level_clr", {28'd0, fifo_level}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'hF0F0 ^ 16'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();       // SHIFT cycle 21 = bit 5
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    chk("t5_level_mid", {28'd0, fifo_level}, 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_sclk", {31'd0, sclk}, 32'd0);
    chk("t5_fsync", {31'd0, fsync}, 32'd0);
    chk("t5_sdata", {31'd0, sdata}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_level", {28'd0, fifo_level}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen = seen | busy | fsync | sclk | sdata;
    end
    chk("t5_no_resume", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
